serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial, LSB-first subtractor computing A − B over WIDTH clock cycles with one bit cell and a registered borrow. It is the inverse-operation counterpart to the serial adder datapath in the same arithmetic library and shares its start/done handshake style, so both units can be swapped in the same test harness. Operands load in parallel. The result, final borrow and optional signed overflow are presented in parallel with a one-cycle done pulse.

## Interface
- WIDTH, default 8: operand and result width. Legal range WIDTH ≥ 2.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the edge that accepts start.
- b  input  WIDTH  subtrahend; captured on the same edge.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; diff and borrow_out are valid while it is high.
- diff  output  WIDTH  a − b mod 2^WIDTH.
- borrow_out  output  1  high when a < b (unsigned).
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on start = 1.
  - SHIFT → DONE after bit WIDTH−1 is processed.
  - DONE → IDLE unconditionally.
- Accept edge (IDLE, start = 1):
  - Load shift registers with a and b.
  - Clear the borrow flip-flop and the bit counter (width $clog2(WIDTH)).
  - Clear the result shift register.
- Each SHIFT edge:
  - d = a0 ^ b0 ^ bin.
  - bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - Shift d into the result MSB and shift the operand registers right.
  - borrow ← bout; counter increments.
- The last SHIFT edge (counter = WIDTH−1) also latches diff ← the full result and borrow_out ← bout.
- diff, borrow_out and ovf hold their values until the next accept edge. They are not cleared on return to IDLE.
- start is ignored in SHIFT and DONE. There is no queueing.
- Operands a and b are don't-care outside the accept edge.
- Reset values, applied asynchronously: state = IDLE; busy, done, diff, borrow_out, ovf, borrow and counter all 0.
- Reset mid-operation aborts the operation immediately. No done pulse follows, and the partial result is discarded.

## Timing
- Edge E0 accepts start. Edges E1..EWIDTH process bits 0..WIDTH−1.
- State is DONE after EWIDTH, so done is high in the cycle between EWIDTH and EWIDTH+1.
- busy rises after E0 and falls after EWIDTH+1.
- Minimum start-to-start spacing is WIDTH+2 cycles. A start held high continuously is accepted at EWIDTH+2.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - Adds the ovf port and its register.
  - On the last SHIFT edge, ovf ← (a[MSB] ^ b[MSB]) & (a[MSB] ^ d), using the MSB bits seen at that edge.
- SERIAL_SUB_OVF_EN undefined:
  - Neither the port nor the register exists.
  - All other behaviour is identical.

## Structure
- Shared package serial_arith_pkg holds:
  - the state encoding constants (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2), shared with the serial adder;
  - the default width constant.
- Sub-module full_subtractor: combinational bit cell with ports A, B, Bin → d, bo. It is instantiated once.
- Top-level contents: FSM, counter, operand/result shift registers, borrow flip-flop.

## Test plan
- WIDTH = 8, a = 200, b = 55, start at E0 → done only during the E8–E9 cycle, diff = 145, borrow_out = 0, busy high E1..E9.
- a = 5, b = 10 → diff = 251 (8'hFB), borrow_out = 1.
- With SERIAL_SUB_OVF_EN: a = 8'h80, b = 8'h01 → diff = 8'h7F, ovf = 1, borrow_out = 0. Without the macro: the port is absent and diff is unchanged.
- Accept a = 9, b = 3, then pulse start with a = 1, b = 1 at E3 → ignored; diff = 6 at done.
- Assert rst asynchronously between E4 and E5 → all outputs 0 immediately and no done pulse. A new start after release yields a correct result.
- Hold start high continuously with a = b = 8'hAA → accepts at E0 and E10; each done shows diff = 0, borrow_out = 0, and prior results persist through IDLE.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic units (adder / subtractor).
//   state_t        : FSM encoding shared by every serial unit so they can be
//                    swapped in the same harness (IDLE=0, SHIFT=1, DONE=2).
//   DEFAULT_WIDTH  : default operand width.
// -----------------------------------------------------------------------------
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Combinational one-bit subtractor cell computing A - B - Bin.
// Ports:
//   A   in  minuend bit
//   B   in  subtrahend bit
//   Bin in  borrow in
//   d   out difference bit
//   bo  out borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic d,
  output logic bo
);

  assign d  = A ^ B ^ Bin;
  // Borrow when A=0,B=1, or when A==B and a borrow is already pending.
  assign bo = (~A & B) | (~(A ^ B) & Bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial LSB-first subtractor: diff = a - b mod 2^WIDTH, one bit per clock
// through a single full_subtractor cell with a registered borrow.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow port ovf.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   request, sampled only in IDLE
//   a, b       in   operands, captured on the accepting edge
//   busy       out  high while in SHIFT or DONE
//   done       out  one-cycle pulse when results are valid
//   diff       out  a - b mod 2^WIDTH (held until next accept)
//   borrow_out out  1 when a < b unsigned (held until next accept)
//   ovf        out  signed overflow (SERIAL_SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_reg;
  logic [WIDTH-1:0]   a_sh_reg;
  logic [WIDTH-1:0]   b_sh_reg;
  logic [WIDTH-1:0]   res_reg;
  logic [WIDTH-1:0]   res_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               borrow_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   diff_reg;
  logic               borrow_out_reg;
`ifdef SERIAL_SUB_OVF_EN
  logic               ovf_reg;
`endif

  logic d_bit;
  logic bout_bit;
  logic last_bit;

  full_subtractor u_cell (
    .A   (a_sh_reg[0]),
    .B   (b_sh_reg[0]),
    .Bin (borrow_reg),
    .d   (d_bit),
    .bo  (bout_bit)
  );

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
  assign res_next = {d_bit, res_reg[WIDTH-1:1]};
  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      res_reg        <= '0;
      cnt_reg        <= '0;
      borrow_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_reg        <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg  <= SHIFT;
            busy_reg   <= 1'b1;
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            res_reg    <= '0;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
          end
        end
        SHIFT: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_reg    <= res_next;
          borrow_reg <= bout_bit;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (last_bit) begin
            state_reg      <= DONE;
            done_reg       <= 1'b1;
            diff_reg       <= res_next;
            borrow_out_reg <= bout_bit;
`ifdef SERIAL_SUB_OVF_EN
            // On the last edge the shift-register LSBs are the operand MSBs.
            ovf_reg        <= (a_sh_reg[0] ^ b_sh_reg[0]) & (a_sh_reg[0] ^ d_bit);
`endif
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign diff       = diff_reg;
  assign borrow_out = borrow_out_reg;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_reg;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed scenarios for serial_subtractor (WIDTH = 8). Outputs are sampled on
// the falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a_in),
    .b          (b_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf        (ovf),
`endif
    .borrow_out (borrow_out)
  );

  // Advance one full clock, ending on a falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Present a request for one edge; returns at the falling edge after E0.
  task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a_in  = av;
    b_in  = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom_range(0, 255);
    b_in  = $urandom_range(0, 255);
  endtask

  // Bounded wait for done; found=0 when the budget expires.
  task automatic wait_done(input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (done === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    step();
    total++;
    if ({busy, done, diff, borrow_out} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b diff=%h borrow=%b required all 0",
               busy, done, diff, borrow_out);
    end
`ifdef SERIAL_SUB_OVF_EN
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got=%b required=0", ovf);
    end
`endif
    rst = 1'b0;
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_busy got=%b required=0", busy);
    end
    $display("reset: busy=%b done=%b diff=%h borrow=%b", busy, done, diff, borrow_out);
  endtask

  // 200 - 55 with cycle-exact done/busy checks.
  task automatic test_basic();
    do_start(8'd200, 8'd55);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL basic_after_e0 got busy=%b done=%b required busy=1 done=0", busy, done);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (done !== (k == 8) || busy !== (k < 9)) begin
        bad++;
        $display("FAIL basic_timing_e%0d got busy=%b done=%b required busy=%b done=%b",
                 k, busy, done, (k < 9), (k == 8));
      end
      if (k == 8) begin
        total++;
        if (diff !== 8'd145 || borrow_out !== 1'b0) begin
          bad++;
          $display("FAIL basic_result got diff=%0d borrow=%b required diff=145 borrow=0",
                   diff, borrow_out);
        end
`ifdef SERIAL_SUB_OVF_EN
        total++;
        if (ovf !== 1'b0) begin
          bad++;
          $display("FAIL basic_ovf got=%b required=0", ovf);
        end
`endif
        $display("op 200-55: diff=%0d borrow=%b", diff, borrow_out);
      end
    end
  endtask

  task automatic test_borrow();
    logic found;
    do_start(8'd5, 8'd10);
    wait_done(20, found);
    total++;
    if (!found) begin
      bad++;
      $display("FAIL borrow_done_timeout got no done required done within 20 cycles");
    end else begin
      total++;
      if (diff !== 8'hFB || borrow_out !== 1'b1) begin
        bad++;
        $display("FAIL borrow_result got diff=%h borrow=%b required diff=fb borrow=1",
                 diff, borrow_out);
      end
    end
    $display("op 5-10: diff=%h borrow=%b", diff, borrow_out);
    step();
    step();
  endtask

  task automatic test_ovf();
    logic found;
    do_start(8'h80, 8'h01);
    wait_done(20, found);
    total++;
    if (!found) begin
      bad++;
      $display("FAIL ovf_done_timeout got no done required done within 20 cycles");
    end else begin
      total++;
      if (diff !== 8'h7F || borrow_out !== 1'b0) begin
        bad++;
        $display("FAIL ovf_result got diff=%h borrow=%b required diff=7f borrow=0",
                 diff, borrow_out);
      end
`ifdef SERIAL_SUB_OVF_EN
      total++;
      if (ovf !== 1'b1) begin
        bad++;
        $display("FAIL ovf_flag got=%b required=1", ovf);
      end
`endif
    end
    $display("op 80-01: diff=%h borrow=%b", diff, borrow_out);
    step();
    step();
  endtask

  // A second start at E3 must be ignored.
  task automatic test_ignore_start();
    int seen;
    do_start(8'd9, 8'd3);
    step();              // after E1
    step();              // after E2
    start = 1'b1;
    a_in  = 8'd1;
    b_in  = 8'd1;
    step();              // after E3
    start = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      step();
      total++;
      if (done !== (k == 8)) begin
        bad++;
        $display("FAIL ignore_timing_e%0d got done=%b required done=%b", k, done, (k == 8));
      end
    end
    total++;
    if (diff !== 8'd6 || borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL ignore_result got diff=%0d borrow=%b required diff=6 borrow=0",
               diff, borrow_out);
    end
    $display("op 9-3 (start at E3 ignored): diff=%0d borrow=%b", diff, borrow_out);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL ignore_no_queue got %0d active cycles required 0", seen);
    end
  endtask

  // Asynchronous reset between E4 and E5, then a clean operation.
  task automatic test_reset_mid();
    int   seen;
    logic found;
    do_start(8'd200, 8'd55);
    step();
    step();
    step();              // after E3
    @(posedge clk);      // E4
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, diff, borrow_out} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got busy=%b done=%b diff=%h borrow=%b required all 0",
               busy, done, diff, borrow_out);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_no_done got %0d active cycles required 0", seen);
    end
    $display("op abort by reset: diff=%h borrow=%b", diff, borrow_out);
    do_start(8'd100, 8'd30);
    wait_done(20, found);
    total++;
    if (!found || diff !== 8'd70 || borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL midreset_recover got found=%b diff=%0d borrow=%b required found=1 diff=70 borrow=0",
               found, diff, borrow_out);
    end
    $display("op 100-30: diff=%0d borrow=%b", diff, borrow_out);
    step();
    step();
  endtask

  // start held high: accepts at E0 and E10, results persist through IDLE.
  task automatic test_back_to_back();
    start = 1'b1;
    a_in  = 8'hAA;
    b_in  = 8'hAA;
    @(posedge clk);
    @(negedge clk);      // after E0
    for (int k = 1; k <= 18; k++) begin
      step();
      total++;
      if (done !== (k == 8 || k == 18) || busy !== (k != 9)) begin
        bad++;
        $display("FAIL b2b_timing_e%0d got busy=%b done=%b required busy=%b done=%b",
                 k, busy, done, (k != 9), (k == 8 || k == 18));
      end
      if (k == 4) begin
        total++;
        if (diff !== 8'd70) begin
          bad++;
          $display("FAIL b2b_prior_hold got diff=%0d required 70", diff);
        end
      end
      if (k == 8 || k == 9 || k == 18) begin
        total++;
        if (diff !== 8'd0 || borrow_out !== 1'b0) begin
          bad++;
          $display("FAIL b2b_result_e%0d got diff=%h borrow=%b required diff=00 borrow=0",
                   k, diff, borrow_out);
        end
      end
      if (k == 8 || k == 18) $display("op aa-aa (held start, e%0d): diff=%h borrow=%b", k, diff, borrow_out);
    end
    start = 1'b0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_ovf();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_subtractor
